// File: rtl/alu_sequencer.sv
// Handshaked sequencer for a signed ALU: single-cycle add/sub/mult, iterative restoring div/mod.
// Define ALU_SEQ_ABORT_EN to add an abort input that cancels an in-flight operation.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
`ifdef ALU_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [31:0]      output1,
    output logic [1:0]       err_code
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [31:0]        out_q, out_d;
    logic [1:0]         err_q, err_d;

    logic [31:0]        a_ext, b_ext, sum, diff, prod;
    logic [31:0]        quo_ext, rem_ext, div_res, mod_res;
    logic [WIDTH:0]     rem_shift;
    logic               trial_ok;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // True when a 32-bit value does not fit in a signed WIDTH-bit field.
    function automatic logic ovf(input logic [31:0] v);
        return !((&v[31:WIDTH-1]) || !(|v[31:WIDTH-1]));
    endfunction

    assign a_ext = {{(32-WIDTH){a_q[WIDTH-1]}}, a_q};
    assign b_ext = {{(32-WIDTH){b_q[WIDTH-1]}}, b_q};
    assign sum   = a_ext + b_ext;
    assign diff  = a_ext - b_ext;
    // Low 32 bits of a product do not depend on signedness, and the exact signed product fits.
    assign prod  = a_ext * b_ext;

    assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial_ok  = rem_shift >= {1'b0, dvs_q};

    assign quo_ext = {{(32-WIDTH){1'b0}}, quo_q};
    assign rem_ext = {{(32-WIDTH){1'b0}}, rem_q[WIDTH-1:0]};
    assign div_res = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_ext : quo_ext;
    assign mod_res = a_q[WIDTH-1] ? -rem_ext : rem_ext;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op_code;
                    a_d    = input1;
                    b_d    = input2;
                    busy_d = 1'b1;
                    if ((op_code == OP_DIV || op_code == OP_MOD) && input2 != '0) begin
                        state_d = S_DIV;
                        quo_d   = mag(input1);
                        dvs_d   = mag(input2);
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                case (op_q)
                    OP_ADD: begin
                        out_d = sum;
                        err_d = {1'b0, ovf(sum)};
                    end
                    OP_SUB: begin
                        out_d = diff;
                        err_d = {1'b0, ovf(diff)};
                    end
                    OP_MUL: begin
                        out_d = prod;
                        err_d = 2'b00;
                    end
                    OP_DIV, OP_MOD: begin
                        out_d = '0;
                        err_d = 2'b10;
                    end
                    default: begin
                        out_d = '0;
                        err_d = 2'b11;
                    end
                endcase
            end
            S_DIV: begin
                if (cnt_q != '0) begin
                    rem_d = trial_ok ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
                    quo_d = {quo_q[WIDTH-2:0], trial_ok};
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                out_d   = (op_q == OP_DIV) ? div_res : mod_res;
                err_d   = 2'b00;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ALU_SEQ_ABORT_EN
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            out_d   = out_q;
            err_d   = err_q;
        end
`endif
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign output1  = out_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, scoreboard of expected results, corner sequences.
module tb_alu_sequencer;

    logic        clk, rst_n, start;
    logic [3:0]  op_code;
    logic [15:0] input1, input2;
    logic        busy, done;
    logic [31:0] output1;
    logic [1:0]  err_code;
`ifdef ALU_SEQ_ABORT_EN
    logic        abort;
`endif

    alu_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_code  (op_code),
        .input1   (input1),
        .input2   (input2),
`ifdef ALU_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .output1  (output1),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_out;
        logic [1:0]  exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic [1:0]  err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at %0t",
                     name, act, $signed(act), exp, $signed(exp), $time);
        end
    endtask

    // Scoreboard side: every done pops one expectation; outputs must not move between dones.
    logic        prev_done;
    logic [31:0] prev_out;
    logic [1:0]  prev_err;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                check("done_consecutive", {31'b0, prev_done}, 32'd0);
                check("sb_has_entry", {31'b0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("output1", output1, mon_e.out);
                    check("err_code", {30'b0, err_code}, {30'b0, mon_e.err});
                end
            end else begin
                check("output1_hold", output1, prev_out);
                check("err_code_hold", {30'b0, err_code}, {30'b0, prev_err});
            end
        end
        prev_done <= done;
        prev_out  <= output1;
        prev_err  <= err_code;
    end

    // Issue one op from an idle DUT; checks busy each cycle and the accept-to-done latency.
    // A nonzero poke re-asserts start with other operands in that cycle while busy.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] eo, input logic [1:0] ee, input int lat, input int poke);
        int seen;
        start   = 1'b1;
        op_code = op;
        input1  = a;
        input2  = b;
        sb.push_back('{eo, ee});
        @(posedge clk); #1;
        start   = 1'b0;
        op_code = 4'($urandom);
        input1  = 16'($urandom);
        input2  = 16'($urandom);
        seen    = 0;
        for (int c = 1; c <= 100 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1;
                check("latency", c, lat);
                check("busy_at_done", {31'b0, busy}, 32'd0);
            end else begin
                check("busy_while_running", {31'b0, busy}, 32'd1);
            end
            if (poke != 0 && c == poke && seen == 0) begin
                start   = 1'b1;
                op_code = 4'd0;
                input1  = 16'd5;
                input2  = 16'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (seen == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op_code  = '0;
        input1   = '0;
        input2   = '0;
`ifdef ALU_SEQ_ABORT_EN
        abort    = 1'b0;
`endif

        vecs.push_back('{4'd0, 16'sd32000,   16'sd16000, 48000,      2'b01, 1});
        vecs.push_back('{4'd1, 16'sd11,      16'sd15,    -4,         2'b00, 1});
        vecs.push_back('{4'd1, 16'sh8000,    16'sd1,     -32769,     2'b01, 1});
        vecs.push_back('{4'd0, 16'sd32767,   16'sd0,     32767,      2'b00, 1});
        vecs.push_back('{4'd0, -16'sd16384,  -16'sd16384, -32768,    2'b00, 1});
        vecs.push_back('{4'd2, 16'sh8000,    16'sh8000,  1073741824, 2'b00, 1});
        vecs.push_back('{4'd2, 16'sd11,      16'sd15,    165,        2'b00, 1});
        vecs.push_back('{4'd3, -16'sd7,      16'sd2,     -3,         2'b00, 18});
        vecs.push_back('{4'd4, -16'sd7,      16'sd2,     -1,         2'b00, 18});
        vecs.push_back('{4'd4, 16'sd7,       -16'sd2,    1,          2'b00, 18});
        vecs.push_back('{4'd3, 16'sd11,      16'sd0,     0,          2'b10, 1});
        vecs.push_back('{4'd4, 16'sd5,       16'sd0,     0,          2'b10, 1});
        vecs.push_back('{4'd9, 16'sd3,       16'sd4,     0,          2'b11, 1});
        vecs.push_back('{4'd15, 16'sd3,      16'sd4,     0,          2'b11, 1});
        vecs.push_back('{4'd3, 16'sh8000,    -16'sd1,    32768,      2'b00, 18});
        vecs.push_back('{4'd4, 16'sh8000,    -16'sd1,    0,          2'b00, 18});
        vecs.push_back('{4'd3, 16'sd100,     16'sd7,     14,         2'b00, 18});
        vecs.push_back('{4'd4, -16'sd100,    -16'sd7,    -2,         2'b00, 18});
        vecs.push_back('{4'd3, 16'sd32767,   16'sh8000,  0,          2'b00, 18});
        vecs.push_back('{4'd4, 16'sd32767,   16'sh8000,  32767,      2'b00, 18});

        repeat (3) @(posedge clk); #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_output1", output1, 32'd0);
        check("reset_err_code", {30'b0, err_code}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_err, vecs[i].lat, 0);

        // start pulsed mid-division with other operands must be ignored
        issue(4'd3, 16'sd1000, -16'sd3, -333, 2'b00, 18, 5);

        // start held high: second op accepted on the edge that ends the done cycle
        start   = 1'b1;
        op_code = 4'd0;
        input1  = 16'd1;
        input2  = 16'd2;
        sb.push_back('{32'd3, 2'b00});
        sb.push_back('{32'd3, 2'b00});
        @(posedge clk); #1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            check("b2b_done", {31'b0, done}, (c % 2 == 1) ? 32'd1 : 32'd0);
            check("b2b_busy", {31'b0, busy}, (c == 2) ? 32'd1 : 32'd0);
            if (c == 2) start = 1'b0;
        end

`ifdef ALU_SEQ_ABORT_EN
        issue(4'd0, 16'd5, 16'd6, 11, 2'b00, 1, 0);
        start   = 1'b1;
        op_code = 4'd3;
        input1  = 16'sd32000;
        input2  = 16'sd16000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        repeat (25) @(posedge clk); #1;
        check("abort_output1_held", output1, 32'd11);
        check("abort_err_held", {30'b0, err_code}, 32'd0);
        issue(4'd3, 16'sd32000, 16'sd16000, 2, 2'b00, 18, 0);
`endif

        // asynchronous reset in the middle of a division
        start   = 1'b1;
        op_code = 4'd3;
        input1  = 16'sd100;
        input2  = 16'sd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_output1", output1, 32'd0);
        check("midreset_err_code", {30'b0, err_code}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (30) @(posedge clk); #1;
        check("post_reset_busy", {31'b0, busy}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Clocked, handshaked front end for the 16-bit signed ALU (add, sub, mult, div, mod).
- Accepts one operation at a time and runs add/sub/mult in one cycle. Div/mod use an iterative restoring shift-subtract divider, replacing the combinational loop divider.
- Presents a 32-bit result, a 2-bit error code and a one-cycle done pulse; sits between the operator-input logic and the display/output stage.

Parameters:
- WIDTH, 16, operand width; result width is fixed at 32 (requires 2*WIDTH <= 32).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only when busy=0.
- op_code  in  4  0 add, 1 sub, 2 mult, 3 div, 4 mod, 5..15 illegal.
- input1  in  WIDTH  signed operand A (dividend).
- input2  in  WIDTH  signed operand B (divisor).
- busy  out  1  high from the accept edge until the edge that raises done.
- done  out  1  one-cycle pulse; output1/err_code valid from this cycle.
- output1  out  32  signed result, held until the next done.
- err_code  out  2  [0] add/sub signed WIDTH-bit overflow; [1] divide/mod by zero; 2'b11 illegal op.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, output1=0, err_code=0, divider regs=0. Assertion mid-operation aborts immediately with no done pulse.
- States: IDLE, EXEC, DIV, FIX.
- IDLE: on start=1 at edge E0, latch op_code, input1 and input2, set busy=1.
  - op 0/1/2/illegal: go to EXEC.
  - op 3/4 with input2!=0: go to DIV; load |A|, |B|, counter=WIDTH, remainder=0.
  - op 3/4 with input2==0: go to EXEC.
- EXEC: at E1 write the result and err_code, done=1, busy=0, return to IDLE. Latency is 1 cycle.
  - add/sub: output1 = sign-extended 32-bit exact sum/difference; err_code[0]=1 when the true result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. output1 still carries the exact value.
  - mult: output1 = full signed product; err_code=0.
  - div/mod by zero: output1=0, err_code=2'b10.
  - illegal op: output1=0, err_code=2'b11.
- DIV: one restoring step per cycle. Shift remainder left taking the MSB of the quotient register, trial-subtract |B|, set the quotient bit if the result is non-negative. Counter decrements and DIV exits to FIX when it reaches 0 (WIDTH cycles).
- FIX: apply signs and register the result, done=1, busy=0, go to IDLE. Div/mod latency from E0 to done edge is WIDTH+2 (18).
  - div: quotient truncates toward zero; negate if the operand signs differ.
  - mod: remainder takes the dividend's sign. |rem| < |B|.
  - Result sign-extended to 32 bits; err_code=0.
  - -32768 / -1 = +32768 (fits in 32 bits, no error); -32768 mod -1 = 0.
- Operands are registered at E0; input changes after E0 have no effect.
- start while busy=1 is ignored, not queued.
- start held high: a new operation is accepted in the IDLE cycle after done (back-to-back throughput = latency+1).
- done never asserts in two consecutive cycles.
- output1 and err_code change only on done edges.

Optional Feature:
- Macro: ALU_SEQ_ABORT_EN.
- With the macro: adds input port abort (1 bit).
  - abort=1 while busy=1: return to IDLE at the next edge, busy=0, no done pulse, output1/err_code keep their previous values.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start is accepted.
- Without the macro: the port does not exist and operations always complete.

Test Plan:
- Reset mid-DIV (start div 100/7, drop rst_n at cycle 5) -> busy=0, done never pulses, output1=0, err_code=0 at once.
- add 32000+16000 -> done 1 cycle after accept, output1=48000, err_code=2'b01. Sub 11-15 -> output1=-4, err_code=0.
- mult -32768*-32768 -> output1=1073741824, err_code=0. Mult 11*15 -> 165.
- div -7/2 -> output1=-3; mod -7/2 -> output1=-1; mod 7/-2 -> output1=1. Each done exactly 18 cycles after accept; busy high the 18 cycles between.
- div 11/0 -> done after 1 cycle, output1=0, err_code=2'b10. Op_code 9 -> output1=0, err_code=2'b11. Start pulsed during a div with different operands -> ignored, div result unaffected.
- ALU_SEQ_ABORT_EN: div 32000/16000 with abort at cycle 6 -> no done, output1 holds the previous result. Next div 32000/16000 -> 2.
